// File: rtl/mig_axi_front_pkg.sv
// Shared constants for the AXI slave front end of the DDR path.
package mig_axi_front_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_BEAT = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

  localparam logic [31:0] BEAT_BYTES = 32'd16;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic        CMD_RD     = 1'b1;
  localparam logic        CMD_WR     = 1'b0;

  // Byte address of beat cnt; wraps at 32 bits with no 4 KB boundary handling.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [7:0] cnt);
    return base + ({24'd0, cnt} * BEAT_BYTES);
  endfunction

endpackage

// File: rtl/mig_axi_front_if.sv
// AXI4 channel bundle between the system interconnect (master) and the DDR front end (slave).
interface mig_axi_front_if #(parameter int ID_W = 4);

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic            awvalid;
  logic            awready;
  logic [127:0]    wdata;
  logic [15:0]     wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [127:0]    rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/mig_axi_front_axi_rr_arb.sv
// Two-requester round-robin between AXI writes and reads; a tie goes to the type not granted last.
module axi_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_wr,
  input  logic req_rd,
  input  logic en,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_rd_q, last_rd_d;

  always_comb begin
    gnt_wr    = en & req_wr & (~req_rd | last_rd_q);
    gnt_rd    = en & req_rd & ~gnt_wr;
    last_rd_d = last_rd_q;
    if (gnt_wr)      last_rd_d = 1'b0;
    else if (gnt_rd) last_rd_d = 1'b1;
  end

  // Flag starts as "read" so the very first tie is won by the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_rd_q <= 1'b1;
    else        last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/mig_axi_front.sv
// AXI4 slave front end: serialises one burst at a time into per-beat req/wdq pushes and drains rdq onto R.
module mig_axi_front
  import mig_axi_front_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic                 mclk,
  input  logic                 mrst_n,
  mig_axi_front_if.slave       axi,
  output logic                 req_wen,
  input  logic                 req_wfull,
  output logic [31:0]          req_waddr,
  output logic                 req_wrd_bwt,
  output logic                 wdq_wen,
  input  logic                 wdq_wfull,
  output logic [127:0]         wdq_wdata,
  output logic                 rdq_rnext,
  input  logic                 rdq_rqempty,
  input  logic [127:0]         rdq_rdata
);

  logic [2:0]      state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      len_q, len_d;
  logic [31:0]     base_q, base_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic            rdone_q, rdone_d;
  logic            gnt_wr, gnt_rd;
  logic            r_last_hs;
  logic            unused_inputs;

  assign unused_inputs = ^{axi.wstrb, axi.wlast, axi.awaddr[3:0], axi.araddr[3:0]};

  axi_rr_arb u_arb (
    .clk    (mclk),
    .rst_n  (mrst_n),
    .req_wr (axi.awvalid),
    .req_rd (axi.arvalid),
    .en     (state_q == ST_IDLE),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    rdone_d     = rdone_q;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = id_q;
    axi.bresp   = RESP_OKAY;
    axi.rid     = id_q;
    axi.rresp   = RESP_OKAY;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rlast   = 1'b0;
    rdq_rnext   = 1'b0;
    req_wen     = 1'b0;
    req_waddr   = '0;
    req_wrd_bwt = CMD_WR;
    wdq_wen     = 1'b0;
    wdq_wdata   = '0;

    // The R channel drains rdq concurrently with request pushes; rdone marks a burst fully returned early.
    if (state_q == ST_RD_REQ || state_q == ST_RD_DATA) begin
      axi.rvalid = ~rdq_rqempty & ~rdone_q;
      axi.rdata  = rdq_rdata;
      axi.rlast  = (rcnt_q == len_q);
      rdq_rnext  = axi.rvalid & axi.rready;
      if (rdq_rnext) rcnt_d = rcnt_q + 8'd1;
    end
    r_last_hs = rdq_rnext & axi.rlast;

    case (state_q)
      ST_IDLE: begin
        axi.awready = gnt_wr;
        axi.arready = gnt_rd;
        if (gnt_wr || gnt_rd) begin
          id_d    = gnt_wr ? axi.awid : axi.arid;
          len_d   = gnt_wr ? axi.awlen : axi.arlen;
          base_d  = gnt_wr ? {axi.awaddr[31:4], 4'h0} : {axi.araddr[31:4], 4'h0};
          cnt_d   = 8'd0;
          rcnt_d  = 8'd0;
          rdone_d = 1'b0;
          state_d = gnt_wr ? ST_WR_BEAT : ST_RD_REQ;
        end
      end
      ST_WR_BEAT: begin
        axi.wready = ~req_wfull & ~wdq_wfull;
        if (axi.wvalid && axi.wready) begin
          req_wen     = 1'b1;
          wdq_wen     = 1'b1;
          req_waddr   = beat_addr(base_q, cnt_q);
          req_wrd_bwt = CMD_WR;
          wdq_wdata   = axi.wdata;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) state_d = ST_IDLE;
      end
      ST_RD_REQ: begin
        if (r_last_hs) rdone_d = 1'b1;
        if (!req_wfull) begin
          req_wen     = 1'b1;
          req_waddr   = beat_addr(base_q, cnt_q);
          req_wrd_bwt = CMD_RD;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = (rdone_q || r_last_hs) ? ST_IDLE : ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rdone_q <= rdone_d;
    end
  end

endmodule

// File: tb/tb_mig_axi_front.sv
// Randomised bench for mig_axi_front: a transaction-level model predicts grants, pushes and R beats.
module tb_mig_axi_front;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    int          stall;
  } txn_t;

  logic         mclk = 1'b0;
  logic         mrst_n;
  logic         req_wen, req_wfull, req_wrd_bwt;
  logic [31:0]  req_waddr;
  logic         wdq_wen, wdq_wfull;
  logic [127:0] wdq_wdata;
  logic         rdq_rnext, rdq_rqempty;
  logic [127:0] rdq_rdata;

  txn_t         wr_q[$];
  txn_t         rd_q[$];
  logic [127:0] rdq_model[$];
  int           n_checks = 0;
  int           n_fail = 0;
  bit           exp_last_rd;

  mig_axi_front_if #(.ID_W(4)) axi ();

  mig_axi_front #(.ID_W(4)) dut (
    .mclk        (mclk),
    .mrst_n      (mrst_n),
    .axi         (axi),
    .req_wen     (req_wen),
    .req_wfull   (req_wfull),
    .req_waddr   (req_waddr),
    .req_wrd_bwt (req_wrd_bwt),
    .wdq_wen     (wdq_wen),
    .wdq_wfull   (wdq_wfull),
    .wdq_wdata   (wdq_wdata),
    .rdq_rnext   (rdq_rnext),
    .rdq_rqempty (rdq_rqempty),
    .rdq_rdata   (rdq_rdata)
  );

  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic txn_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input int stall);
    txn_t t;
    t.id = id; t.addr = addr; t.len = len; t.stall = stall;
    return t;
  endfunction

  task automatic tick();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput(tag, {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready,
                      axi.rvalid, axi.rid, axi.rresp, axi.rlast, req_wen, req_waddr,
                      req_wrd_bwt, wdq_wen, rdq_rnext}, '0);
    checkOutput({tag, "_data"}, {axi.rdata, wdq_wdata}, '0);
  endtask

  task automatic writeBody(input txn_t t);
    int           i = 0;
    int           cyc = 0;
    int           stall_left = 0;
    bit           stalled = 0;
    bit           push;
    bit           done = 0;
    logic [31:0]  base;
    logic [162:0] exp_p;
    base = {t.addr[31:4], 4'h0};
    while (i <= int'(t.len) && cyc < 64 * (int'(t.len) + 2)) begin
      axi.wvalid = ($urandom_range(3) != 0);
      axi.wdata  = rand128();
      axi.wlast  = (i == int'(t.len));
      req_wfull  = ($urandom_range(7) == 0);
      if (i == t.stall && !stalled) begin
        stall_left = 3;
        stalled    = 1;
      end
      wdq_wfull = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #1;
      push = axi.wvalid && !req_wfull && !wdq_wfull;
      checkOutput("wready", axi.wready, !req_wfull && !wdq_wfull);
      exp_p = '0;
      if (push) exp_p = {1'b1, 1'b1, 1'b0, base + 32'(i) * 32'd16, axi.wdata};
      checkOutput("wpush", {req_wen, wdq_wen, req_wrd_bwt, req_waddr, wdq_wdata}, exp_p);
      tick();
      cyc++;
      if (push) i++;
    end
    checkOutput("wbeats", i, int'(t.len) + 1);
    axi.wvalid = 1'b0;
    req_wfull  = 1'b0;
    wdq_wfull  = 1'b0;
    cyc = 0;
    while (!done && cyc < 8) begin
      axi.bready = ($urandom_range(2) != 0) || (cyc == 5);
      #1;
      checkOutput("bresp", {axi.bvalid, axi.bid, axi.bresp}, {1'b1, t.id, 2'b00});
      done = axi.bready;
      tick();
      cyc++;
    end
    axi.bready = 1'b0;
  endtask

  task automatic readBody(input txn_t t, input int stop_after);
    int           p = 0;
    int           r = 0;
    int           cyc = 0;
    int           len;
    bit           push, rv;
    logic [31:0]  base;
    logic [127:0] head;
    logic [34:0]  exp_p;
    len  = int'(t.len);
    base = {t.addr[31:4], 4'h0};
    while ((p <= len || r <= len) && cyc < 64 * (len + 2) && (stop_after == 0 || cyc < stop_after)) begin
      req_wfull   = ($urandom_range(4) == 0);
      axi.rready  = ($urandom_range(1) == 1);
      rdq_rqempty = (rdq_model.size() == 0) || ($urandom_range(3) == 0);
      head        = (rdq_model.size() != 0) ? rdq_model[0] : '0;
      rdq_rdata   = head;
      #1;
      push  = (p <= len) && !req_wfull;
      exp_p = '0;
      if (push) exp_p = {3'b101, base + 32'(p) * 32'd16};
      checkOutput("rpush", {req_wen, wdq_wen, req_wrd_bwt, req_waddr}, exp_p);
      rv = !rdq_rqempty && (r <= len);
      checkOutput("rvalid", {axi.rvalid, rdq_rnext}, {rv, rv && axi.rready});
      if (rv) checkOutput("rbeat", {axi.rdata, axi.rlast, axi.rid, axi.rresp}, {head, r == len, t.id, 2'b00});
      tick();
      cyc++;
      if (push) p++;
      if (rv && axi.rready) begin
        void'(rdq_model.pop_front());
        r++;
      end
    end
    if (stop_after == 0) checkOutput("rdone", {p, r}, {len + 1, len + 1});
    axi.rready  = 1'b0;
    req_wfull   = 1'b0;
    rdq_rqempty = (rdq_model.size() == 0);
  endtask

  // Drains wr_q/rd_q, holding every pending valid high so ties are resolved by the DUT.
  task automatic applyStimulus(input int stop_after);
    int   guard = 0;
    bit   w, r, pick_wr;
    txn_t t;
    while ((wr_q.size() != 0 || rd_q.size() != 0) && guard < 100) begin
      w = (wr_q.size() != 0);
      r = (rd_q.size() != 0);
      axi.awvalid = w;
      axi.arvalid = r;
      if (w) begin
        axi.awid = wr_q[0].id; axi.awaddr = wr_q[0].addr; axi.awlen = wr_q[0].len;
      end
      if (r) begin
        axi.arid = rd_q[0].id; axi.araddr = rd_q[0].addr; axi.arlen = rd_q[0].len;
      end
      pick_wr = w && (!r || exp_last_rd);
      #1;
      checkOutput("grant", {axi.awready, axi.arready}, {pick_wr, !pick_wr});
      tick();
      if (pick_wr) begin
        axi.awvalid = 1'b0;
        t = wr_q.pop_front();
        exp_last_rd = 1'b0;
        writeBody(t);
      end else begin
        axi.arvalid = 1'b0;
        t = rd_q.pop_front();
        exp_last_rd = 1'b1;
        repeat (int'(t.len) + 1) rdq_model.push_back(rand128());
        readBody(t, stop_after);
      end
      guard++;
    end
    axi.awvalid = 1'b0;
    axi.arvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mrst_n      = 1'b0;
    exp_last_rd = 1'b1;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = '1; axi.wlast = 0;
    axi.bready = 0; axi.rready = 0;
    req_wfull = 0; wdq_wfull = 0; rdq_rqempty = 1; rdq_rdata = 0;
    repeat (3) @(negedge mclk);
    #1 checkIdleOutputs("reset");
    @(negedge mclk);
    mrst_n = 1'b1;

    $display("[TB] tie at reset exit: single write then read burst");
    wr_q.push_back(mk(4'h3, 32'h0000_0100, 8'd0, -1));
    rd_q.push_back(mk(4'h5, 32'h0000_2000, 8'd3, -1));
    applyStimulus(0);

    $display("[TB] alternating ties, stalled burst, address wrap");
    wr_q.push_back(mk(4'h9, 32'h0000_1008, 8'd3, 1));
    wr_q.push_back(mk(4'h2, 32'hFFFF_FFF0, 8'd1, -1));
    rd_q.push_back(mk(4'h6, 32'h0000_4010, 8'd2, -1));
    rd_q.push_back(mk(4'hA, 32'hFFFF_FFE0, 8'd4, -1));
    applyStimulus(0);

    $display("[TB] random transaction mix");
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 1 + int'($urandom_range(2)); j++)
        wr_q.push_back(mk(4'($urandom), $urandom, 8'($urandom_range(7)), int'($urandom_range(4))));
      for (int j = 0; j < int'($urandom_range(2)); j++)
        rd_q.push_back(mk(4'($urandom), $urandom, 8'($urandom_range(7)), -1));
      applyStimulus(0);
    end

    $display("[TB] reset in the middle of a read burst");
    rd_q.push_back(mk(4'h7, 32'h0000_3000, 8'd7, -1));
    applyStimulus(4);
    mrst_n = 1'b0;
    #1 checkIdleOutputs("midreset");
    rdq_model.delete();
    rdq_rqempty = 1'b1;
    exp_last_rd = 1'b1;
    @(negedge mclk);
    mrst_n = 1'b1;
    wr_q.push_back(mk(4'hC, 32'h0000_5000, 8'd2, -1));
    applyStimulus(0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
